// File: rtl/cmd_ctrl_pkg.sv
// Shared definitions for the command controller: frame opcodes, ALU operand
// register addresses and the frame-parser state set.
package cmd_ctrl_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int unsigned ALU_A_ADDR = 0;
  localparam int unsigned ALU_B_ADDR = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_ALU_A,
    ST_ALU_B,
    ST_ALU_FUN,
    ST_ALU_WAIT,
    ST_TX
  } state_e;

endpackage

// File: rtl/cmd_resp_seq.sv
// Response sequencer: holds up to two result bytes and hands them to the UART
// transmitter low byte first over a valid/busy handshake.
module cmd_resp_seq #(
  parameter int unsigned DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [2*DATA_W-1:0]   i_data,
  input  logic [1:0]            i_cnt,
  input  logic                  i_tx_busy,
  output logic [DATA_W-1:0]     o_tx_data,
  output logic                  o_tx_valid,
  output logic                  o_done
);

  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_tx_valid;
  logic [1:0]        r_cnt;
  logic              w_xfer;

  assign w_xfer     = r_tx_valid & ~i_tx_busy;
  // done marks the cycle in which the last pending byte is accepted
  assign o_done     = w_xfer & (r_cnt == 2'd1);
  assign o_tx_data  = r_tx_data;
  assign o_tx_valid = r_tx_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi       <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_cnt      <= '0;
    end else if (i_load) begin
      r_hi       <= i_data[2*DATA_W-1:DATA_W];
      r_tx_data  <= i_data[DATA_W-1:0];
      r_cnt      <= i_cnt;
      r_tx_valid <= (i_cnt != 2'd0);
    end else if (w_xfer) begin
      if (r_cnt == 2'd2) begin
        r_cnt     <= 2'd1;
        r_tx_data <= r_hi;
      end else begin
        r_cnt      <= 2'd0;
        r_tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cmd_ctrl.sv
// Command controller: parses framed UART bytes, drives register-file and ALU
// strobes, and returns read/ALU results through the response sequencer.
module cmd_ctrl
  import cmd_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned FUN_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     rx_data,
  input  logic                  rx_valid,
  output logic                  rf_wr_en,
  output logic                  rf_rd_en,
  output logic [ADDR_W-1:0]     rf_addr,
  output logic [DATA_W-1:0]     rf_wr_data,
  input  logic [DATA_W-1:0]     rf_rd_data,
  input  logic                  rf_rd_valid,
  output logic                  alu_en,
  output logic [FUN_W-1:0]      alu_fun,
  input  logic [2*DATA_W-1:0]   alu_out,
  input  logic                  alu_out_valid,
  output logic [DATA_W-1:0]     tx_data,
  output logic                  tx_valid,
  input  logic                  tx_busy,
  output logic                  cmd_err,
  output logic                  ctrl_busy
);

  state_e              r_state, w_state;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic                r_rf_wr_en, w_rf_wr_en;
  logic                r_rf_rd_en, w_rf_rd_en;
  logic [ADDR_W-1:0]   r_rf_addr, w_rf_addr;
  logic [DATA_W-1:0]   r_rf_wr_data, w_rf_wr_data;
  logic                r_alu_en, w_alu_en;
  logic [FUN_W-1:0]    r_alu_fun, w_alu_fun;
  logic                r_cmd_err, w_cmd_err;
  logic                r_ctrl_busy, w_ctrl_busy;
  logic                w_load;
  logic [2*DATA_W-1:0] w_load_data;
  logic [1:0]          w_load_cnt;
  logic                w_done;

  cmd_resp_seq #(.DATA_W(DATA_W)) u_resp (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_data     (w_load_data),
    .i_cnt      (w_load_cnt),
    .i_tx_busy  (tx_busy),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .o_done     (w_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state;
  end

  always_comb begin
    w_state      = r_state;
    w_addr       = r_addr;
    w_rf_wr_en   = 1'b0;
    w_rf_rd_en   = 1'b0;
    w_rf_addr    = r_rf_addr;
    w_rf_wr_data = r_rf_wr_data;
    w_alu_en     = 1'b0;
    w_alu_fun    = r_alu_fun;
    w_cmd_err    = 1'b0;
    w_load       = 1'b0;
    w_load_data  = '0;
    w_load_cnt   = '0;
    case (r_state)
      ST_IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            DATA_W'(CMD_RF_WR):   w_state = ST_WR_ADDR;
            DATA_W'(CMD_RF_RD):   w_state = ST_RD_ADDR;
            DATA_W'(CMD_ALU_OP):  w_state = ST_ALU_A;
            DATA_W'(CMD_ALU_NOP): w_state = ST_ALU_FUN;
            default:              w_cmd_err = 1'b1;
          endcase
        end
      end
      ST_WR_ADDR: begin
        if (rx_valid) begin
          w_addr  = rx_data[ADDR_W-1:0];
          w_state = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        if (rx_valid) begin
          w_rf_wr_en   = 1'b1;
          w_rf_addr    = r_addr;
          w_rf_wr_data = rx_data;
          w_state      = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        if (rx_valid) begin
          w_rf_rd_en = 1'b1;
          w_rf_addr  = rx_data[ADDR_W-1:0];
          w_state    = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        w_cmd_err = rx_valid;
        if (rf_rd_valid) begin
          w_load      = 1'b1;
          w_load_data = {{DATA_W{1'b0}}, rf_rd_data};
          w_load_cnt  = 2'd1;
          w_state     = ST_TX;
        end
      end
      ST_ALU_A: begin
        if (rx_valid) begin
          w_rf_wr_en   = 1'b1;
          w_rf_addr    = ADDR_W'(ALU_A_ADDR);
          w_rf_wr_data = rx_data;
          w_state      = ST_ALU_B;
        end
      end
      ST_ALU_B: begin
        if (rx_valid) begin
          w_rf_wr_en   = 1'b1;
          w_rf_addr    = ADDR_W'(ALU_B_ADDR);
          w_rf_wr_data = rx_data;
          w_state      = ST_ALU_FUN;
        end
      end
      ST_ALU_FUN: begin
        if (rx_valid) begin
          w_alu_fun = rx_data[FUN_W-1:0];
          w_alu_en  = 1'b1;
          w_state   = ST_ALU_WAIT;
        end
      end
      ST_ALU_WAIT: begin
        w_cmd_err = rx_valid;
        if (alu_out_valid) begin
          w_load      = 1'b1;
          w_load_data = alu_out;
          w_load_cnt  = 2'd2;
          w_state     = ST_TX;
        end
      end
      ST_TX: begin
        // a byte arriving in the final-transfer cycle is still dropped
        w_cmd_err = rx_valid;
        if (w_done) w_state = ST_IDLE;
      end
      default: w_state = ST_IDLE;
    endcase
    w_ctrl_busy = (w_state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr       <= '0;
      r_rf_wr_en   <= 1'b0;
      r_rf_rd_en   <= 1'b0;
      r_rf_addr    <= '0;
      r_rf_wr_data <= '0;
      r_alu_en     <= 1'b0;
      r_alu_fun    <= '0;
      r_cmd_err    <= 1'b0;
      r_ctrl_busy  <= 1'b0;
    end else begin
      r_addr       <= w_addr;
      r_rf_wr_en   <= w_rf_wr_en;
      r_rf_rd_en   <= w_rf_rd_en;
      r_rf_addr    <= w_rf_addr;
      r_rf_wr_data <= w_rf_wr_data;
      r_alu_en     <= w_alu_en;
      r_alu_fun    <= w_alu_fun;
      r_cmd_err    <= w_cmd_err;
      r_ctrl_busy  <= w_ctrl_busy;
    end
  end

  assign rf_wr_en   = r_rf_wr_en;
  assign rf_rd_en   = r_rf_rd_en;
  assign rf_addr    = r_rf_addr;
  assign rf_wr_data = r_rf_wr_data;
  assign alu_en     = r_alu_en;
  assign alu_fun    = r_alu_fun;
  assign cmd_err    = r_cmd_err;
  assign ctrl_busy  = r_ctrl_busy;

endmodule

// File: tb/tb_cmd_ctrl.sv
// Bench for cmd_ctrl: register-file and ALU device models, a frame-level
// reference model producing expected strobes and response bytes.
module tb_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rf_wr_en, rf_rd_en, alu_en, tx_valid, cmd_err, ctrl_busy;
  logic [3:0]  rf_addr, alu_fun;
  logic [7:0]  rf_wr_data, tx_data;
  logic [7:0]  rf_rd_data = '0;
  logic        rf_rd_valid = 1'b0;
  logic [15:0] alu_out = '0;
  logic        alu_out_valid = 1'b0;
  logic        tx_busy = 1'b0;

  always #5 clk = ~clk;

  cmd_ctrl #(.DATA_W(8), .ADDR_W(4), .FUN_W(4)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr),
    .rf_wr_data(rf_wr_data), .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid),
    .alu_en(alu_en), .alu_fun(alu_fun), .alu_out(alu_out),
    .alu_out_valid(alu_out_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_busy(tx_busy), .cmd_err(cmd_err), .ctrl_busy(ctrl_busy)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  rf_mem  [16];
  logic [7:0]  ref_mem [16];
  logic [11:0] exp_wr  [$];
  logic [3:0]  exp_rd  [$];
  logic [3:0]  exp_alu [$];
  logic [7:0]  exp_tx  [$];
  int exp_err = 0, obs_err = 0;
  int extra_wr = 0, extra_rd = 0, extra_alu = 0, extra_tx = 0;
  int rd_cd = -1, alu_cd = -1;
  int rd_lat = 2, alu_lat = 3;
  logic [3:0]  rd_a = '0, alu_f_p = '0;
  logic        rnd_busy = 1'b0;
  logic        prev_hold = 1'b0;
  logic [7:0]  prev_data = '0;

  function automatic logic [15:0] alu_model(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      4'd0:    return 16'(a) + 16'(b);
      4'd1:    return 16'(a) - 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      4'd3:    return {8'h00, a & b};
      4'd4:    return {8'h00, a | b};
      4'd5:    return {8'h00, a ^ b};
      default: return {a, b};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive device responses, observe at the falling edge.
  task automatic step();
    logic [15:0] r;
    rf_rd_valid   = 1'b0;
    alu_out_valid = 1'b0;
    if (rd_cd > 0) begin
      rd_cd--;
      if (rd_cd == 0) begin
        rf_rd_valid = 1'b1;
        rf_rd_data  = rf_mem[rd_a];
        rd_cd       = -1;
      end
    end
    if (alu_cd > 0) begin
      alu_cd--;
      if (alu_cd == 0) begin
        r             = alu_model(alu_f_p, rf_mem[0], rf_mem[1]);
        alu_out_valid = 1'b1;
        alu_out       = r;
        alu_cd        = -1;
      end
    end
    if (rnd_busy) tx_busy = 1'($urandom_range(0, 1));
    @(negedge clk);
    if (rst) begin
      if (prev_hold) begin
        check("tx_hold_valid", 32'(tx_valid), 32'd1);
        check("tx_hold_data", 32'(tx_data), 32'(prev_data));
      end
      prev_hold = tx_valid && tx_busy;
      prev_data = tx_data;
      if (rf_wr_en) begin
        rf_mem[rf_addr] = rf_wr_data;
        if (exp_wr.size() > 0) check("rf_wr", 32'({rf_addr, rf_wr_data}), 32'(exp_wr.pop_front()));
        else extra_wr++;
      end
      if (rf_rd_en) begin
        rd_a  = rf_addr;
        rd_cd = rd_lat;
        if (exp_rd.size() > 0) check("rf_rd_addr", 32'(rf_addr), 32'(exp_rd.pop_front()));
        else extra_rd++;
      end
      if (alu_en) begin
        alu_f_p = alu_fun;
        alu_cd  = alu_lat;
        if (exp_alu.size() > 0) check("alu_fun", 32'(alu_fun), 32'(exp_alu.pop_front()));
        else extra_alu++;
      end
      if (tx_valid && !tx_busy) begin
        if (exp_tx.size() > 0) check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
        else extra_tx++;
      end
      if (cmd_err) obs_err++;
    end else begin
      prev_hold = 1'b0;
      rd_cd     = -1;
      alu_cd    = -1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    step();
  endtask

  task automatic frame_end(input string tag);
    int n = 0;
    while (ctrl_busy !== 1'b0 && n < 500) begin
      step();
      n++;
    end
    check({tag, "_idle"}, 32'(ctrl_busy), 32'd0);
    step();
    step();
    check({tag, "_wr_left"},  32'(exp_wr.size()),  32'd0);
    check({tag, "_rd_left"},  32'(exp_rd.size()),  32'd0);
    check({tag, "_alu_left"}, 32'(exp_alu.size()), 32'd0);
    check({tag, "_tx_left"},  32'(exp_tx.size()),  32'd0);
    check({tag, "_extra"},    32'(extra_wr + extra_rd + extra_alu + extra_tx), 32'd0);
    check({tag, "_err_cnt"},  32'(obs_err), 32'(exp_err));
    exp_wr.delete(); exp_rd.delete(); exp_alu.delete(); exp_tx.delete();
    extra_wr = 0; extra_rd = 0; extra_alu = 0; extra_tx = 0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    exp_wr.push_back({a[3:0], d});
    ref_mem[a[3:0]] = d;
    send_byte(8'hAA); send_byte(a); send_byte(d);
  endtask

  task automatic do_read(input logic [7:0] a);
    exp_rd.push_back(a[3:0]);
    exp_tx.push_back(ref_mem[a[3:0]]);
    send_byte(8'hBB); send_byte(a);
  endtask

  task automatic do_alu_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
    logic [15:0] r;
    exp_wr.push_back({4'd0, a});
    exp_wr.push_back({4'd1, b});
    ref_mem[0] = a;
    ref_mem[1] = b;
    r = alu_model(f[3:0], a, b);
    exp_alu.push_back(f[3:0]);
    exp_tx.push_back(r[7:0]);
    exp_tx.push_back(r[15:8]);
    send_byte(8'hCC); send_byte(a); send_byte(b); send_byte(f);
  endtask

  task automatic do_alu_nop(input logic [7:0] f, input bit inject, input logic [7:0] inj);
    logic [15:0] r;
    r = alu_model(f[3:0], ref_mem[0], ref_mem[1]);
    exp_alu.push_back(f[3:0]);
    exp_tx.push_back(r[7:0]);
    exp_tx.push_back(r[15:8]);
    send_byte(8'hDD); send_byte(f);
    if (inject) begin
      exp_err++;
      send_byte(inj);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"},   32'(rf_wr_en),   32'd0);
    check({tag, "_rd_en"},   32'(rf_rd_en),   32'd0);
    check({tag, "_addr"},    32'(rf_addr),    32'd0);
    check({tag, "_wdata"},   32'(rf_wr_data), 32'd0);
    check({tag, "_alu_en"},  32'(alu_en),     32'd0);
    check({tag, "_alu_fun"}, 32'(alu_fun),    32'd0);
    check({tag, "_tx_data"}, 32'(tx_data),    32'd0);
    check({tag, "_tx_vld"},  32'(tx_valid),   32'd0);
    check({tag, "_err"},     32'(cmd_err),    32'd0);
    check({tag, "_busy"},    32'(ctrl_busy),  32'd0);
  endtask

  initial begin
    logic [7:0] b;
    int n;
    for (int i = 0; i < 16; i++) begin
      rf_mem[i]  = 8'($urandom);
      ref_mem[i] = rf_mem[i];
    end
    @(posedge clk);
    #1;
    step(); step();
    check_reset_outputs("por");
    rst = 1'b1;
    step();

    // write then read back through the response path
    do_write(8'h05, 8'h3C);
    frame_end("t1_wr");
    do_read(8'h05);
    frame_end("t1_rd");

    // loaded ALU operation: 7 + 3
    do_alu_op(8'h07, 8'h03, 8'h00);
    frame_end("t2");

    // response held off by a busy transmitter
    tx_busy = 1'b1;
    do_alu_nop(8'h02, 1'b0, 8'h00);
    n = 0;
    while (tx_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check("t3_txv_rise", 32'(tx_valid), 32'd1);
    repeat (50) step();
    check("t3_txv_held", 32'(tx_valid), 32'd1);
    check("t3_tx_pending", 32'(exp_tx.size()), 32'd2);
    tx_busy = 1'b0;
    frame_end("t3");

    // illegal opcode, then a byte dropped while waiting on the ALU
    exp_err++;
    send_byte(8'h55);
    do_alu_nop(8'h04, 1'b1, 8'hAA);
    frame_end("t4");

    // reset in the middle of a write frame
    send_byte(8'hAA); send_byte(8'h05);
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    step();
    rst = 1'b1;
    step();
    exp_err++;
    send_byte(8'h06);
    do_read(8'h06);
    frame_end("t5");

    // randomized frames against the reference model
    rnd_busy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 4))
        0: do_write(8'($urandom), 8'($urandom));
        1: do_read(8'($urandom));
        2: do_alu_op(8'($urandom), 8'($urandom), 8'($urandom_range(0, 7)));
        3: do_alu_nop(8'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom));
        default: begin
          do b = 8'($urandom);
          while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD);
          exp_err++;
          send_byte(b);
        end
      endcase
      frame_end("rnd");
      repeat ($urandom_range(0, 3)) step();
    end
    rnd_busy = 1'b0;
    tx_busy  = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
